irq_ctrl6502: RTL and testbench

Memory-mapped interrupt controller that sequences the `irq` and `nmi` inputs of `cpu6502`. It sits on the CPU bus beside the ROM and RAM decoders. It collects up to eight peripheral interrupt sources, latches their rising edges, applies a software mask and drives a level IRQ to the CPU. It also converts an external NMI request edge into a fixed-width NMI pulse the CPU can reliably sample.

---
 rtl/irq_ctrl6502_pkg.sv | 26 ++
 rtl/irq_edge_det.sv | 27 ++
 rtl/irq_ctrl6502.sv | 161 ++++++++++++++++
 tb/tb_irq_ctrl6502.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl6502_pkg.sv
// irq_ctrl6502_pkg: register offsets, reset constants, the NMI state type
// and a priority helper shared by the interrupt controller.
package irq_ctrl6502_pkg;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_MASK   = 2'd1;
  localparam logic [1:0] REG_VECTOR = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam logic [7:0] MASK_RST = 8'h00;
  localparam logic [7:0] CTRL_RST = 8'h01;

  typedef enum logic {
    NMI_IDLE,
    NMI_HOLD
  } nmi_state_e;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_set = 3'(i);
    end
  endfunction

endpackage

// File: rtl/irq_edge_det.sv
// irq_edge_det: sample register plus rising-edge detect, W bits wide.
// The sample register is deliberately not reset: it keeps following the
// input while the block is in reset, so a line that is already high when
// reset releases is not mistaken for a fresh edge.
module irq_edge_det #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic [W-1:0] d,
  output logic [W-1:0] rise
);

  logic [W-1:0] smp_d, smp_q;

  // next sample is simply the current input
  always_comb begin
    smp_d = d;
  end

  // sample register
  always_ff @(posedge clk) begin
    smp_q <= smp_d;
  end

  assign rise = d & ~smp_q;

endmodule

// File: rtl/irq_ctrl6502.sv
// irq_ctrl6502: memory-mapped IRQ/NMI sequencer for cpu6502.
// Four registers at BASE_ADDR: STATUS (W1C pending), MASK, VECTOR, CTRL.
// Optional feature macro IRQ_CTRL6502_NMI_EN builds the NMI pulse machine
// and CTRL.NMI_EN; without it nmi is tied low and CTRL reads 0.
module irq_ctrl6502
  import irq_ctrl6502_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFE00,
  parameter int          NSRC      = 8,
  parameter int          NMI_HOLD  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     addr,
  input  logic [7:0]      wdata,
  input  logic            rw,
  input  logic            phi2,
  output logic [7:0]      rdata,
  output logic            sel,
  input  logic [NSRC-1:0] src,
  input  logic            nmi_src,
  output logic            irq,
  output logic            nmi
);

  localparam logic [7:0] SRC_BITS = 8'((1 << NSRC) - 1);

  logic [NSRC-1:0] src_rise;
  logic [7:0]      rise8;
  logic            commit, wr_status, wr_mask;
  logic [7:0]      enabled, vector, ctrl_rd;

  logic       phi2_d, phi2_q;
  logic [7:0] pending_d, pending_q;
  logic [7:0] mask_d, mask_q;
  logic       irq_d, irq_q;

  irq_edge_det #(.W(NSRC)) u_src_edge (
    .clk  (clk),
    .d    (src),
    .rise (src_rise)
  );

  // bus decode; the phi2 edge test makes a long write commit exactly once
  always_comb begin
    rise8            = '0;
    rise8[NSRC-1:0]  = src_rise;
    sel              = (addr[15:2] == BASE_ADDR[15:2]);
    commit           = sel & ~rw & phi2 & ~phi2_q;
    wr_status        = commit && (addr[1:0] == REG_STATUS);
    wr_mask          = commit && (addr[1:0] == REG_MASK);
    enabled          = pending_q & mask_q;
    vector           = {|enabled, 4'b0000, lowest_set(enabled)};
  end

  // read mux, zero when the block is not addressed
  always_comb begin
    rdata = 8'h00;
    if (sel) begin
      case (addr[1:0])
        REG_STATUS: rdata = pending_q;
        REG_MASK:   rdata = mask_q;
        REG_VECTOR: rdata = vector;
        default:    rdata = ctrl_rd;
      endcase
    end
  end

  // next state for the IRQ side; a rise ORs in after the clear, so set wins
  always_comb begin
    phi2_d    = phi2;
    pending_d = ((pending_q & ~(wr_status ? wdata : 8'h00)) | rise8) & SRC_BITS;
    mask_d    = wr_mask ? (wdata & SRC_BITS) : mask_q;
    irq_d     = |(pending_q & mask_q);
  end

  // IRQ-side registers
  always_ff @(posedge clk) begin
    if (reset) begin
      phi2_q    <= 1'b0;
      pending_q <= 8'h00;
      mask_q    <= MASK_RST;
      irq_q     <= 1'b0;
    end else begin
      phi2_q    <= phi2_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      irq_q     <= irq_d;
    end
  end

  assign irq = irq_q;

`ifdef IRQ_CTRL6502_NMI_EN
  localparam logic [3:0] HOLD_LOAD = 4'(NMI_HOLD - 1);

  logic       nmi_rise;
  logic       wr_ctrl;
  nmi_state_e state_d, state_q;
  logic [3:0] cnt_d, cnt_q;
  logic       nmi_out_d, nmi_out_q;
  logic       nmi_en_d, nmi_en_q;

  irq_edge_det #(.W(1)) u_nmi_edge (
    .clk  (clk),
    .d    (nmi_src),
    .rise (nmi_rise)
  );

  // NMI pulse machine: a rise in IDLE starts a NMI_HOLD-cycle pulse;
  // rises during HOLD are dropped and NMI_EN is only looked at in IDLE
  always_comb begin
    wr_ctrl   = commit && (addr[1:0] == REG_CTRL);
    nmi_en_d  = wr_ctrl ? wdata[0] : nmi_en_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    nmi_out_d = 1'b0;
    case (state_q)
      NMI_IDLE: begin
        if (nmi_rise && nmi_en_q) begin
          state_d   = NMI_HOLD;
          cnt_d     = HOLD_LOAD;
          nmi_out_d = 1'b1;
        end
      end
      default: begin
        if (cnt_q == 4'd0) begin
          state_d = NMI_IDLE;
        end else begin
          cnt_d     = cnt_q - 4'd1;
          nmi_out_d = 1'b1;
        end
      end
    endcase
  end

  // NMI-side registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= NMI_IDLE;
      cnt_q     <= 4'd0;
      nmi_out_q <= 1'b0;
      nmi_en_q  <= CTRL_RST[0];
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      nmi_out_q <= nmi_out_d;
      nmi_en_q  <= nmi_en_d;
    end
  end

  assign ctrl_rd = {7'b0000000, nmi_en_q};
  assign nmi     = nmi_out_q;
`else
  logic unused_nmi_src;
  assign unused_nmi_src = nmi_src;
  assign ctrl_rd        = 8'h00;
  assign nmi            = 1'b0;
`endif

endmodule

// File: tb/tb_irq_ctrl6502.sv
module tb_irq_ctrl6502;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        rw, phi2;
  logic [7:0]  rdata;
  logic        sel;
  logic [7:0]  src;
  logic        nmi_src;
  logic        irq, nmi;

  localparam logic [15:0] B = 16'hFE00;
  localparam int K_RD = 0, K_IRQ = 1, K_NMI = 2, K_SEL = 3;
`ifdef IRQ_CTRL6502_NMI_EN
  localparam logic HAS_NMI = 1'b1;
`else
  localparam logic HAS_NMI = 1'b0;
`endif
  localparam logic [7:0] CTRL_EXP = {7'b0, HAS_NMI};

  irq_ctrl6502 dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .rw(rw),
    .phi2(phi2), .rdata(rdata), .sel(sel), .src(src), .nmi_src(nmi_src),
    .irq(irq), .nmi(nmi)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    int         kind;
    string      name;
    logic [7:0] val;
  } exp_t;

  exp_t sbq[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic push(input int kind, input string name, input logic [7:0] val, input int dly);
    exp_t e;
    e.cyc = cyc + dly; e.kind = kind; e.name = name; e.val = val;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    logic [7:0] act;
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc == cyc) begin
        case (sbq[i].kind)
          K_RD:    act = rdata;
          K_IRQ:   act = {7'b0, irq};
          K_NMI:   act = {7'b0, nmi};
          default: act = {7'b0, sel};
        endcase
        n_cmp++;
        if (act !== sbq[i].val) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h (cycle %0d)", sbq[i].name, act, sbq[i].val, cyc);
        end
        sbq.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input int hold);
    addr = a; wdata = d; rw = 1'b0; phi2 = 1'b1;
    tick(hold);
    phi2 = 1'b0; rw = 1'b1; addr = 16'h0000;
    tick(1);
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [7:0] e, input string name);
    addr = a; rw = 1'b1;
    push(K_RD, name, e, 0);
    tick(1);
    addr = 16'h0000;
  endtask

  initial begin
    reset = 1'b1; addr = 16'h0000; wdata = 8'h00; rw = 1'b1; phi2 = 1'b0;
    src = 8'h00; nmi_src = 1'b0;
    tick(2);
    reset = 1'b0;
    n_cmp++;
    if (irq !== 1'b0) begin
      n_bad++;
      $display("FAIL direct_rst_irq: got %b expected 0", irq);
    end
    n_cmp++;
    if (nmi !== 1'b0) begin
      n_bad++;
      $display("FAIL direct_rst_nmi: got %b expected 0", nmi);
    end
    push(K_IRQ, "rst_irq", 8'h00, 0);
    push(K_NMI, "rst_nmi", 8'h00, 0);
    bus_read(B + 16'd0, 8'h00, "rst_status");
    bus_read(B + 16'd1, 8'h00, "rst_mask");
    bus_read(B + 16'd2, 8'h00, "rst_vector");
    bus_read(B + 16'd3, CTRL_EXP, "rst_ctrl");
    addr = B + 16'd3; push(K_SEL, "sel_in_window", 8'h01, 0); tick(1);
    addr = B + 16'd4; push(K_SEL, "sel_next_window", 8'h00, 0); tick(1);
    bus_read(16'h1234, 8'h00, "rdata_unselected");

    bus_write(B + 16'd1, 8'h04, 1);
    src[2] = 1'b1;
    push(K_IRQ, "irq_before", 8'h00, 1);
    push(K_IRQ, "irq_after", 8'h01, 2);
    bus_read(B + 16'd0, 8'h00, "status_pre_edge");
    bus_read(B + 16'd0, 8'h04, "status_set");
    bus_read(B + 16'd2, 8'h82, "vector_src2");
    push(K_IRQ, "irq_at_commit", 8'h01, 1);
    push(K_IRQ, "irq_cleared", 8'h00, 2);
    bus_write(B + 16'd0, 8'h04, 1);
    bus_read(B + 16'd0, 8'h00, "status_cleared");
    src[2] = 1'b0;

    bus_write(B + 16'd1, 8'hFF, 1);
    src[5] = 1'b1; src[1] = 1'b1;
    tick(1);
    bus_read(B + 16'd2, 8'h81, "vector_prio");
    bus_read(B + 16'd0, 8'h22, "status_two");
    src[1] = 1'b0;
    tick(1);
    addr = B; wdata = 8'h02; rw = 1'b0; phi2 = 1'b1;
    tick(1);
    src[1] = 1'b1;
    tick(3);
    phi2 = 1'b0; rw = 1'b1; addr = 16'h0000;
    tick(1);
    bus_read(B + 16'd0, 8'h22, "held_write_once");
    push(K_IRQ, "irq_prio", 8'h01, 0);
    bus_read(B + 16'd2, 8'h81, "vector_after_hold");

    bus_write(B + 16'd0, 8'hFF, 1);
    src = 8'h00;
    tick(1);
    bus_read(B + 16'd0, 8'h00, "status_all_clear");
    push(K_IRQ, "irq_all_clear", 8'h00, 0);
    bus_read(B + 16'd2, 8'h00, "vector_none");
    addr = B; wdata = 8'h08; rw = 1'b0; phi2 = 1'b1; src[3] = 1'b1;
    tick(1);
    phi2 = 1'b0; rw = 1'b1; addr = 16'h0000;
    tick(1);
    bus_read(B + 16'd0, 8'h08, "set_beats_clear");
    push(K_IRQ, "irq_src3", 8'h01, 0);
    bus_write(B + 16'd0, 8'h08, 1);
    bus_read(B + 16'd0, 8'h00, "status_src3_clr");
    src[3] = 1'b0;

    nmi_src = 1'b1;
    for (int d = 0; d < 8; d++)
      push(K_NMI, "nmi_pulse", (d >= 1 && d <= 4) ? CTRL_EXP : 8'h00, d);
    tick(1);
    nmi_src = 1'b0;
    tick(1);
    nmi_src = 1'b1;
    tick(1);
    nmi_src = 1'b0;
    tick(6);

    bus_write(B + 16'd3, 8'h00, 1);
    bus_read(B + 16'd3, 8'h00, "ctrl_off");
    nmi_src = 1'b1;
    for (int d = 1; d < 4; d++) push(K_NMI, "nmi_disabled", 8'h00, d);
    tick(4);
    n_cmp++;
    if (nmi !== 1'b0) begin
      n_bad++;
      $display("FAIL direct_nmi_disabled: got %b expected 0", nmi);
    end
    nmi_src = 1'b0;
    bus_write(B + 16'd3, 8'h01, 1);
    bus_read(B + 16'd3, CTRL_EXP, "ctrl_on");

    tick(1);
    nmi_src = 1'b1;
    push(K_NMI, "nmi_pre_rst1", CTRL_EXP, 1);
    push(K_NMI, "nmi_pre_rst2", CTRL_EXP, 2);
    tick(2);
    reset = 1'b1; src[0] = 1'b1;
    push(K_NMI, "nmi_rst_cut", 8'h00, 1);
    push(K_IRQ, "irq_rst", 8'h00, 1);
    tick(1);
    reset = 1'b0; nmi_src = 1'b0;
    tick(2);
    bus_read(B + 16'd0, 8'h00, "no_edge_after_rst");
    bus_read(B + 16'd1, 8'h00, "mask_after_rst");
    bus_read(B + 16'd3, CTRL_EXP, "ctrl_after_rst");
    push(K_NMI, "nmi_after_rst", 8'h00, 0);
    src[0] = 1'b0;
    tick(1);
    src[0] = 1'b1;
    tick(1);
    bus_read(B + 16'd0, 8'h01, "edge_after_toggle");
    #1;
    n_cmp++;
    if (sel !== 1'b0) begin
      n_bad++;
      $display("FAIL direct_sel_idle: got %b expected 0", sel);
    end
    n_cmp++;
    if (rdata !== 8'h00) begin
      n_bad++;
      $display("FAIL direct_rdata_idle: got %h expected 00", rdata);
    end

    tick(3);
    foreach (sbq[i]) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: never sampled, expected %h", sbq[i].name, sbq[i].val);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
